osc_startup_seq: RTL and testbench

- Power-on and STOP-mode oscillator sequencer. It produces the control inputs that the clock generator consumes: osc_ena, osc_stable, clk_ena, reset and n_test_reset.
- It counts oscillator warm-up cycles and holds the clock generator in reset for a fixed window after power-on.
- It gates clocks off on a CPU STOP request and re-runs the warm-up on wake.
- It sits between the pad/reset logic and the clock generator at SoC top.

---
 rtl/osc_startup_seq.sv | 138 +++++++++++++
 tb/tb_osc_startup_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/osc_startup_seq.sv
// Oscillator power-on / STOP-mode sequencer driving the clock generator's enable and reset controls.
// Optional `OSC_TEST_BYPASS_EN adds input test_1 to short-circuit the warm-up and reset-hold counts.
module osc_startup_seq #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 16384,
    parameter int unsigned RESET_HOLD    = 8
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       stop_req,
    input  logic       wake,
`ifdef OSC_TEST_BYPASS_EN
    input  logic       test_1,
`endif
    output logic       osc_ena,
    output logic       osc_stable,
    output logic       clk_ena,
    output logic       reset,
    output logic       n_test_reset,
    output logic [2:0] state
);

    localparam longint unsigned CNT_RANGE   = longint'(1) << CNT_W;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);

    // Counts must fit the counter and be non-zero
    if (STABLE_CYCLES == 0 || longint'(STABLE_CYCLES) > CNT_RANGE) begin : g_bad_stable
        $error("osc_startup_seq: STABLE_CYCLES out of range");
    end
    if (RESET_HOLD == 0 || longint'(RESET_HOLD) > CNT_RANGE) begin : g_bad_hold
        $error("osc_startup_seq: RESET_HOLD out of range");
    end

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_WARMUP = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_STOP   = 3'd4,
        ST_WAKE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             osc_ena_d, osc_stable_d, clk_ena_d, reset_d;
    logic             bypass_c;

`ifdef OSC_TEST_BYPASS_EN
    assign bypass_c = test_1;
`else
    assign bypass_c = 1'b0;
`endif

    // State, counter and all outputs registered together
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            osc_ena      <= 1'b0;
            osc_stable   <= 1'b0;
            clk_ena      <= 1'b0;
            reset        <= 1'b1;
            n_test_reset <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            osc_ena      <= osc_ena_d;
            osc_stable   <= osc_stable_d;
            clk_ena      <= clk_ena_d;
            reset        <= reset_d;
            n_test_reset <= ~reset_d;
        end
    end

    assign state = state_q;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        osc_ena_d    = osc_ena;
        osc_stable_d = osc_stable;
        clk_ena_d    = clk_ena;
        reset_d      = reset;
        case (state_q)
            ST_OFF: begin
                state_d   = ST_WARMUP;
                osc_ena_d = 1'b1;
                cnt_d     = '0;
            end
            ST_WARMUP, ST_WAKE: begin
                if (cnt_q == STABLE_LAST || bypass_c) begin
                    state_d      = (state_q == ST_WARMUP) ? ST_HOLD : ST_RUN;
                    osc_stable_d = 1'b1;
                    clk_ena_d    = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST || bypass_c) begin
                    state_d = ST_RUN;
                    reset_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // wake overrides a simultaneous stop request
                if (stop_req && !wake) begin
                    state_d      = ST_STOP;
                    osc_ena_d    = 1'b0;
                    osc_stable_d = 1'b0;
                    clk_ena_d    = 1'b0;
                end
            end
            ST_STOP: begin
                if (wake) begin
                    state_d   = ST_WAKE;
                    osc_ena_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d      = ST_OFF;
                cnt_d        = '0;
                osc_ena_d    = 1'b0;
                osc_stable_d = 1'b0;
                clk_ena_d    = 1'b0;
                reset_d      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_osc_startup_seq.sv
// Directed bench for osc_startup_seq: expected output vectors are queued as stimulus is applied
// and compared against the DUT after each edge.
module tb_osc_startup_seq;

    localparam int unsigned SC = 16;
    localparam int unsigned RH = 8;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       stop_req = 1'b0;
    logic       wake = 1'b0;
`ifdef OSC_TEST_BYPASS_EN
    logic       test_1 = 1'b0;
`endif
    logic       osc_ena, osc_stable, clk_ena, reset, n_test_reset;
    logic [2:0] state;

    osc_startup_seq #(.CNT_W(16), .STABLE_CYCLES(SC), .RESET_HOLD(RH)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .stop_req     (stop_req),
        .wake         (wake),
`ifdef OSC_TEST_BYPASS_EN
        .test_1       (test_1),
`endif
        .osc_ena      (osc_ena),
        .osc_stable   (osc_stable),
        .clk_ena      (clk_ena),
        .reset        (reset),
        .n_test_reset (n_test_reset),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // {state, osc_ena, osc_stable, clk_ena, reset, n_test_reset}
    function automatic logic [7:0] ev(input logic [2:0] st, input logic oe, input logic os,
                                      input logic ce, input logic rs);
        return {st, oe, os, ce, rs, ~rs};
    endfunction

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [7:0] obs;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e   = q.pop_front();
        obs = {state, osc_ena, osc_stable, clk_ena, reset, n_test_reset};
        checks++;
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
        end
    endtask

    // One clock edge, then check the queued expectation away from the edge
    task automatic cyc(input string tag, input logic [7:0] val);
        push(tag, val);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic power_on(input string pfx, input logic noise);
        n_reset = 1'b1;
        stop_req = noise;
        wake = noise;
        cyc({pfx, "_e1"}, ev(3'd1, 1, 0, 0, 1));
        for (int i = 2; i <= SC; i++) cyc({pfx, "_warm"}, ev(3'd1, 1, 0, 0, 1));
        cyc({pfx, "_stable"}, ev(3'd2, 1, 1, 1, 1));
        for (int i = 1; i < RH; i++) cyc({pfx, "_hold"}, ev(3'd2, 1, 1, 1, 1));
        stop_req = 1'b0;
        wake = 1'b0;
        cyc({pfx, "_run"}, ev(3'd3, 1, 1, 1, 0));
    endtask

    task automatic wake_run(input string pfx);
        for (int i = 1; i < SC; i++) cyc({pfx, "_waking"}, ev(3'd5, 1, 0, 0, 0));
        cyc({pfx, "_woken"}, ev(3'd3, 1, 1, 1, 0));
    endtask

    initial begin
        // Power-on reset held for 4 edges
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        push("reset_state", ev(3'd0, 0, 0, 0, 1));
        compare();

        power_on("pwr", 1'b0);
        cyc("run_idle", ev(3'd3, 1, 1, 1, 0));

        // Wake beats a simultaneous stop in RUN
        stop_req = 1'b1;
        wake = 1'b1;
        cyc("run_stop_wake", ev(3'd3, 1, 1, 1, 0));
        wake = 1'b0;
        cyc("stop_entry", ev(3'd4, 0, 0, 0, 0));
        stop_req = 1'b0;
        cyc("stop_idle", ev(3'd4, 0, 0, 0, 0));

        // Simultaneous pair in STOP goes to WAKE
        stop_req = 1'b1;
        wake = 1'b1;
        cyc("stop_wake_pair", ev(3'd5, 1, 0, 0, 0));
        wake = 1'b0;
        wake_run("wk1");
        stop_req = 1'b0;
        cyc("run_after_wake", ev(3'd3, 1, 1, 1, 0));

        // Plain stop then plain wake
        stop_req = 1'b1;
        cyc("stop_entry2", ev(3'd4, 0, 0, 0, 0));
        stop_req = 1'b0;
        wake = 1'b1;
        cyc("wake_entry", ev(3'd5, 1, 0, 0, 0));
        wake = 1'b0;
        wake_run("wk2");

        // Asynchronous reset in WARMUP at cnt=7
        n_reset = 1'b0;
        #1;
        push("async_reset_run", ev(3'd0, 0, 0, 0, 1));
        compare();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        cyc("rewarm_e1", ev(3'd1, 1, 0, 0, 1));
        for (int i = 2; i <= 8; i++) cyc("rewarm", ev(3'd1, 1, 0, 0, 1));
        n_reset = 1'b0;
        #1;
        push("async_reset_warm", ev(3'd0, 0, 0, 0, 1));
        compare();
        @(posedge clk);
        #1;
        cyc("held_in_reset", ev(3'd0, 0, 0, 0, 1));

        // stop_req/wake ignored during WARMUP and HOLD
        power_on("pwr2", 1'b1);

`ifdef OSC_TEST_BYPASS_EN
        n_reset = 1'b0;
        #2;
        n_reset = 1'b1;
        cyc("byp_e1", ev(3'd1, 1, 0, 0, 1));
        cyc("byp_e2", ev(3'd1, 1, 0, 0, 1));
        test_1 = 1'b1;
        cyc("byp_stable", ev(3'd2, 1, 1, 1, 1));
        cyc("byp_run", ev(3'd3, 1, 1, 1, 0));
        test_1 = 1'b0;
`endif

        if (q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
